// File: rtl/dec_fpr_pkg.sv
// Shared types and sizing for the FP register-file writeback scheduler.
// Provides the register address/data types, scoreboard width, the load
// credit limit and a helper that turns an (enable, address) pair into a
// one-hot register vector for the busy scoreboard.
package dec_fpr_pkg;

    localparam int NUM_FPR  = 32;
    localparam int LD_MAX   = 4;
    localparam int LD_CNT_W = 3;

    typedef logic [4:0]          fpr_addr_t;
    typedef logic [31:0]         fpr_data_t;
    typedef logic [NUM_FPR-1:0]  fpr_vec_t;
    typedef logic [LD_CNT_W-1:0] ld_cnt_t;

    localparam ld_cnt_t LD_MAX_CNT = ld_cnt_t'(LD_MAX);

    // One-hot register vector, all zero when the request is not enabled.
    function automatic fpr_vec_t fpr_onehot(input logic en, input fpr_addr_t addr);
        fpr_vec_t v;
        v       = '0;
        v[addr] = en;
        return v;
    endfunction

endpackage

// File: rtl/dec_fpr_scoreboard.sv
// Per-register busy scoreboard for long-latency FP destinations.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   set_vec / clr_vec        registers becoming busy / completing this cycle
//   rden0..2, raddr0..2      decode source reads checked for RAW hazards
//   dec_wen, dec_waddr       decode destination checked for WAW hazards
//   busy                     current busy vector
//   stall                    hazard against the current (not next) busy state
module dec_fpr_scoreboard
    import dec_fpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  fpr_vec_t  set_vec,
    input  fpr_vec_t  clr_vec,
    input  logic      rden0,
    input  fpr_addr_t raddr0,
    input  logic      rden1,
    input  fpr_addr_t raddr1,
    input  logic      rden2,
    input  fpr_addr_t raddr2,
    input  logic      dec_wen,
    input  fpr_addr_t dec_waddr,
    output fpr_vec_t  busy,
    output logic      stall
);

    fpr_vec_t busy_q;
    fpr_vec_t busy_d;

    // A new issue to the same register overrides a completing write.
    always_comb begin
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The stall uses the registered state, so a register written back this
    // cycle still stalls; the FPR has no bypass and is updated at the edge.
    always_comb begin
        stall = (rden0   & busy_q[raddr0])
              | (rden1   & busy_q[raddr1])
              | (rden2   & busy_q[raddr2])
              | (dec_wen & busy_q[dec_waddr]);
    end

    assign busy = busy_q;

endmodule

// File: rtl/dec_fpr_wb_sched.sv
// FP register-file writeback scheduler.
// Routes the two fixed-latency pipe results to write ports 0/1, the
// non-blockable load return to port 2, and squeezes the div/sqrt result into
// whichever port is left free. Tracks outstanding loads, the pending div/sqrt
// result, a busy scoreboard for decode hazards and a sticky protocol error.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   i0_*, i1_*                            pipe0/pipe1 result writes
//   ld_*                                  FP load return (no back-pressure)
//   div_wb_valid/rd/data, div_wb_ready    div/sqrt result handshake
//   ld_issue_*, div_issue_*               new long-latency destinations
//   rden0..2/raddr0..2, dec_wen/dec_waddr decode hazard queries
//   wen0..2/waddr0..2/wd0..2              FPR write ports
//   fpr_busy, dec_stall                   scoreboard state and hazard stall
//   ld_credit_avail, div_busy, sb_err     load credit, div pending, error
module dec_fpr_wb_sched
    import dec_fpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i0_wen,
    input  fpr_addr_t i0_waddr,
    input  fpr_data_t i0_wd,
    input  logic      i1_wen,
    input  fpr_addr_t i1_waddr,
    input  fpr_data_t i1_wd,
    input  logic      ld_wen,
    input  fpr_addr_t ld_waddr,
    input  fpr_data_t ld_wd,
    input  logic      div_wb_valid,
    input  fpr_addr_t div_wb_rd,
    input  fpr_data_t div_wb_data,
    output logic      div_wb_ready,
    input  logic      ld_issue_valid,
    input  fpr_addr_t ld_issue_rd,
    input  logic      div_issue_valid,
    input  fpr_addr_t div_issue_rd,
    input  logic      rden0,
    input  fpr_addr_t raddr0,
    input  logic      rden1,
    input  fpr_addr_t raddr1,
    input  logic      rden2,
    input  fpr_addr_t raddr2,
    input  logic      dec_wen,
    input  fpr_addr_t dec_waddr,
    output fpr_addr_t waddr0,
    output logic      wen0,
    output fpr_data_t wd0,
    output fpr_addr_t waddr1,
    output logic      wen1,
    output fpr_data_t wd1,
    output fpr_addr_t waddr2,
    output logic      wen2,
    output fpr_data_t wd2,
    output fpr_vec_t  fpr_busy,
    output logic      dec_stall,
    output logic      ld_credit_avail,
    output logic      div_busy,
    output logic      sb_err
);

    ld_cnt_t  ld_cnt_q, ld_cnt_d;
    logic     div_busy_q, div_busy_d;
    logic     sb_err_q, sb_err_d;
    logic     div_acc;
    fpr_vec_t set_vec, clr_vec;
    logic     err_now;

    // Port assignment. Loads own port 2 whenever present; div takes port 2
    // when no load returns, otherwise port 1 if pipe1 is idle.
    always_comb begin
        div_wb_ready = ~ld_wen | ~i1_wen;
        div_acc      = div_wb_valid & div_wb_ready;

        wen0   = i0_wen;
        waddr0 = i0_waddr;
        wd0    = i0_wd;

        wen1   = i1_wen;
        waddr1 = i1_waddr;
        wd1    = i1_wd;
        if (!i1_wen && ld_wen && div_acc) begin
            wen1   = 1'b1;
            waddr1 = div_wb_rd;
            wd1    = div_wb_data;
        end

        wen2   = ld_wen;
        waddr2 = ld_waddr;
        wd2    = ld_wd;
        if (!ld_wen && div_acc) begin
            wen2   = 1'b1;
            waddr2 = div_wb_rd;
            wd2    = div_wb_data;
        end
    end

    // Scoreboard updates, pending counters and protocol error detection.
    always_comb begin
        set_vec = fpr_onehot(ld_issue_valid, ld_issue_rd)
                | fpr_onehot(div_issue_valid, div_issue_rd);
        clr_vec = fpr_onehot(ld_wen, ld_waddr)
                | fpr_onehot(div_acc, div_wb_rd);

        // Counter saturates so a protocol error cannot wrap it around.
        ld_cnt_d = ld_cnt_q;
        if (ld_issue_valid && ld_wen) begin
            ld_cnt_d = ld_cnt_q;
        end else if (ld_issue_valid && ld_cnt_q != LD_MAX_CNT) begin
            ld_cnt_d = ld_cnt_q + ld_cnt_t'(1);
        end else if (ld_wen && ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - ld_cnt_t'(1);
        end

        div_busy_d = div_busy_q;
        if (div_issue_valid) begin
            div_busy_d = 1'b1;
        end else if (div_acc) begin
            div_busy_d = 1'b0;
        end

        err_now = (ld_issue_valid  & fpr_busy[ld_issue_rd])
                | (div_issue_valid & fpr_busy[div_issue_rd])
                | (ld_issue_valid  & (ld_cnt_q == LD_MAX_CNT))
                | (ld_wen          & (ld_cnt_q == '0))
                | (div_issue_valid & div_busy_q)
                | (i0_wen          & fpr_busy[i0_waddr])
                | (i1_wen          & fpr_busy[i1_waddr])
                | (wen0 & wen1 & (waddr0 == waddr1))
                | (wen0 & wen2 & (waddr0 == waddr2))
                | (wen1 & wen2 & (waddr1 == waddr2));
        sb_err_d = sb_err_q | err_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q   <= '0;
            div_busy_q <= 1'b0;
            sb_err_q   <= 1'b0;
        end else begin
            ld_cnt_q   <= ld_cnt_d;
            div_busy_q <= div_busy_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign ld_credit_avail = (ld_cnt_q < LD_MAX_CNT);
    assign div_busy        = div_busy_q;
    assign sb_err          = sb_err_q;

    dec_fpr_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_vec   (set_vec),
        .clr_vec   (clr_vec),
        .rden0     (rden0),
        .raddr0    (raddr0),
        .rden1     (rden1),
        .raddr1    (raddr1),
        .rden2     (rden2),
        .raddr2    (raddr2),
        .dec_wen   (dec_wen),
        .dec_waddr (dec_waddr),
        .busy      (fpr_busy),
        .stall     (dec_stall)
    );

endmodule
